// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM state encoding and
// the constant the external iteration counter is loaded with.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        INIT = 2'b01,
        RUN  = 2'b10,
        DONE = 2'b11
    } state_e;

    // Preload so the counter carries out after exactly n increments.
    function automatic int unsigned cnt_init_val(input int unsigned n, input int unsigned cw);
        int unsigned m;
        m = 32'd1 << cw;
        return (m - (n % m)) % m;
    endfunction

endpackage

// File: rtl/shift_add_multiplier_if.sv
// Operand/result handshake between the operand source (master) and the
// multiplier (slave).
interface shift_add_multiplier_if #(
    parameter int unsigned N = 8
);
    logic             start;
    logic [N-1:0]     a;
    logic [N-1:0]     b;
    logic             busy;
    logic             done;
    logic [2*N-1:0]   product;

    modport master (output start, a, b, input busy, done, product);
    modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/shift_add_datapath.sv
// Multiplicand/accumulator/multiplier registers, the N+1 bit adder and the
// result register of the shift-and-add multiplier.
module shift_add_datapath #(
    parameter int unsigned N = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic             step,
    input  logic             capture,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    output logic [2*N-1:0]   product
);

    logic [N-1:0]   a_q, a_d;
    logic [N:0]     p_q, p_d;
    logic [N-1:0]   q_q, q_d;
    logic [2*N-1:0] product_q, product_d;
    logic [N:0]     s;

    always_comb begin
        // P[N] is always zero after a shift, so adding the full P equals adding P[N-1:0].
        s         = p_q + {1'b0, {N{q_q[0]}} & a_q};
        a_d       = a_q;
        p_d       = p_q;
        q_d       = q_q;
        product_d = product_q;
        if (ld) begin
            a_d = a;
            p_d = '0;
            q_d = b;
        end else if (step) begin
            {p_d, q_d} = {s, q_q} >> 1;
        end
        if (capture) begin
            product_d = {p_q[N-1:0], q_q};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q       <= '0;
            p_q       <= '0;
            q_q       <= '0;
            product_q <= '0;
        end else begin
            a_q       <= a_d;
            p_q       <= p_d;
            q_q       <= q_d;
            product_q <= product_d;
        end
    end

    assign product = product_q;

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier; step count is kept by an
// external counter whose carry-out marks the last partial product.
module shift_add_multiplier
    import mult_pkg::*;
#(
    parameter  int unsigned N  = 8,
    localparam int unsigned CW = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    shift_add_multiplier_if.slave bus,
    input  logic                 cnt_co,
    output logic                 cnt_load,
    output logic                 cnt_count,
    output logic [CW-1:0]        cnt_init
);

    localparam logic [CW-1:0] CNT_INIT = CW'(cnt_init_val(N, CW));

    state_e state_q, state_d;
    logic   done_q, done_d;
    logic   ld, step, capture;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ld        = 1'b0;
        step      = 1'b0;
        capture   = 1'b0;
        cnt_load  = 1'b0;
        cnt_count = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    ld      = 1'b1;
                    state_d = INIT;
                end
            end
            INIT: begin
                cnt_load = 1'b1;
                state_d  = RUN;
            end
            RUN: begin
                if (cnt_co) begin
                    capture = 1'b1;
                    state_d = DONE;
                end else begin
                    step      = 1'b1;
                    cnt_count = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign done_d   = capture;
    assign cnt_init = CNT_INIT;
    assign bus.busy = (state_q == INIT) || (state_q == RUN);
    assign bus.done = done_q;

    shift_add_datapath #(.N(N)) u_datapath (
        .clk     (clk),
        .rst     (rst),
        .ld      (ld),
        .step    (step),
        .capture (capture),
        .a       (bus.a),
        .b       (bus.b),
        .product (bus.product)
    );

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier (N=8 and N=5 instances), each
// driving a behavioural model of the iteration counter.
`timescale 1ns/1ps
module tb_shift_add_multiplier;

    localparam int unsigned N   = 8;
    localparam int unsigned CW  = $clog2(N);
    localparam int unsigned N5  = 5;
    localparam int unsigned CW5 = $clog2(N5);

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cnt_rst;
    always #5 clk = ~clk;
    assign cnt_rst = ~rst;

    shift_add_multiplier_if #(.N(N))  bus8 ();
    shift_add_multiplier_if #(.N(N5)) bus5 ();

    logic          co8, load8, count8;
    logic [CW-1:0] init8, c8;
    logic           co5, load5, count5;
    logic [CW5-1:0] init5, c5;

    shift_add_multiplier #(.N(N)) dut8 (
        .clk(clk), .rst(rst), .bus(bus8),
        .cnt_co(co8), .cnt_load(load8), .cnt_count(count8), .cnt_init(init8)
    );

    shift_add_multiplier #(.N(N5)) dut5 (
        .clk(clk), .rst(rst), .bus(bus5),
        .cnt_co(co5), .cnt_load(load5), .cnt_count(count5), .cnt_init(init5)
    );

    // Counter: load sets value and clears co, count increments with carry into co.
    always_ff @(posedge clk or posedge cnt_rst) begin
        if (cnt_rst) begin
            c8 <= '0; co8 <= 1'b0;
        end else if (load8) begin
            c8 <= init8; co8 <= 1'b0;
        end else if (count8) begin
            {co8, c8} <= {1'b0, c8} + (CW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge cnt_rst) begin
        if (cnt_rst) begin
            c5 <= '0; co5 <= 1'b0;
        end else if (load5) begin
            c5 <= init5; co5 <= 1'b0;
        end else if (count5) begin
            {co5, c5} <= {1'b0, c5} + (CW5+1)'(1);
        end
    end

    int unsigned cyc = 0;
    always_ff @(posedge clk) cyc <= cyc + 1;

    int unsigned sb8[$];
    int unsigned sb5[$];
    int errors = 0;
    int checks = 0;
    int unsigned done8_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: every done pulse pops the oldest expected product.
    always @(negedge clk) begin
        logic [63:0] e;
        if (rst && bus8.done) begin
            done8_cnt++;
            e = '1;
            if (sb8.size() != 0) e = 64'(sb8.pop_front());
            chk("product8", 64'(bus8.product), e);
        end
        if (rst && bus5.done) begin
            e = '1;
            if (sb5.size() != 0) e = 64'(sb5.pop_front());
            chk("product5", 64'(bus5.product), e);
        end
    end

    task automatic start_op(input bit sel, input int unsigned av, input int unsigned bv);
        @(negedge clk);
        if (sel) begin
            bus5.start = 1'b1; bus5.a = 5'(av); bus5.b = 5'(bv); sb5.push_back(av * bv);
        end else begin
            bus8.start = 1'b1; bus8.a = 8'(av); bus8.b = 8'(bv); sb8.push_back(av * bv);
        end
        @(posedge clk);
        #1;
        bus8.start = 1'b0; bus5.start = 1'b0;
        bus8.a = 8'($urandom); bus8.b = 8'($urandom);
        bus5.a = 5'($urandom); bus5.b = 5'($urandom);
    endtask

    task automatic wait_done(input bit sel, output int unsigned lat, output int unsigned nload,
                             output int unsigned ncount, output int unsigned nbusy,
                             output int unsigned novl);
        lat = 0; nload = 0; ncount = 0; nbusy = 0; novl = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            nload  += sel ? int'(load5)     : int'(load8);
            ncount += sel ? int'(count5)    : int'(count8);
            nbusy  += sel ? int'(bus5.busy) : int'(bus8.busy);
            novl   += sel ? int'(load5 && count5) : int'(load8 && count8);
            if (sel ? bus5.done : bus8.done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic mult8(input string tag, input int unsigned av, input int unsigned bv);
        int unsigned lat, nl, nc, nb, no;
        start_op(1'b0, av, bv);
        wait_done(1'b0, lat, nl, nc, nb, no);
        chk({tag, "_latency"}, 64'(lat), 64'(N + 3));
        chk({tag, "_ncount"},  64'(nc),  64'(N));
        chk({tag, "_nload"},   64'(nl),  64'd1);
        chk({tag, "_nbusy"},   64'(nb),  64'(N + 2));
        chk({tag, "_overlap"}, 64'(no),  64'd0);
        @(negedge clk);
        chk({tag, "_done_width"}, 64'(bus8.done), 64'd0);
    endtask

    initial begin
        int unsigned lat, nl, nc, nb, no, d0;
        int unsigned t[3];
        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
        bus5.start = 1'b0; bus5.a = '0; bus5.b = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy",    64'(bus8.busy),    64'd0);
        chk("rst_done",    64'(bus8.done),    64'd0);
        chk("rst_product", 64'(bus8.product), 64'd0);
        chk("rst_load",    64'(load8),        64'd0);
        chk("rst_count",   64'(count8),       64'd0);
        chk("cnt_init8",   64'(init8),        64'd0);
        chk("cnt_init5",   64'(init5),        64'd3);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        mult8("m13x11", 13, 11);
        mult8("m255x255", 255, 255);
        mult8("m0x77", 0, 77);
        mult8("m200x1", 200, 1);

        // start during RUN must be ignored
        d0 = done8_cnt;
        start_op(1'b0, 9, 7);
        repeat (3) @(negedge clk);
        bus8.start = 1'b1; bus8.a = 8'd3; bus8.b = 8'd3;
        @(negedge clk);
        bus8.start = 1'b0;
        wait_done(1'b0, lat, nl, nc, nb, no);
        chk("ignored_start_latency", 64'(lat), 64'(N + 3 - 4));
        repeat (N + 5) @(negedge clk);
        chk("ignored_start_dones", 64'(done8_cnt - d0), 64'd1);
        mult8("m3x3", 3, 3);

        // asynchronous reset during the 4th RUN cycle
        start_op(1'b0, 50, 60);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_busy",    64'(bus8.busy),    64'd0);
        chk("midrst_done",    64'(bus8.done),    64'd0);
        chk("midrst_product", 64'(bus8.product), 64'd0);
        chk("midrst_count",   64'(count8),       64'd0);
        sb8.delete();
        @(negedge clk);
        rst = 1'b1;
        mult8("m6x6", 6, 6);

        // N=5 instance
        start_op(1'b1, 31, 31);
        wait_done(1'b1, lat, nl, nc, nb, no);
        chk("n5_latency", 64'(lat), 64'(N5 + 3));
        chk("n5_ncount",  64'(nc),  64'(N5));
        chk("n5_nload",   64'(nl),  64'd1);

        // back-to-back with start held high
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = 8'd2; bus8.b = 8'd3; sb8.push_back(6);
        for (int i = 0; i < 3; i++) begin
            wait_done(1'b0, lat, nl, nc, nb, no);
            chk("b2b_seen", 64'(lat != 0), 64'd1);
            t[i] = cyc;
            if (i == 0) begin
                bus8.a = 8'd250; bus8.b = 8'd17; sb8.push_back(250 * 17);
            end else if (i == 1) begin
                bus8.a = 8'd99; bus8.b = 8'd201; sb8.push_back(99 * 201);
            end else begin
                bus8.start = 1'b0;
            end
        end
        chk("b2b_gap1", 64'(t[1] - t[0]), 64'(N + 4));
        chk("b2b_gap2", 64'(t[2] - t[1]), 64'(N + 4));
        repeat (N + 5) @(negedge clk);
        chk("hold_product", 64'(bus8.product), 64'(99 * 201));
        chk("sb8_drained", 64'(sb8.size()), 64'd0);
        chk("sb5_drained", 64'(sb5.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
